// File: rtl/fully_pipelined_adder_core.sv
// Ripple-carry adder pipelined one bit per stage: stage k resolves sum bit k and the carry into
// bit k+1, so {carry, s} = a + b + c emerges WIDTH enabled edges after the operands are sampled.
module fully_pipelined_adder_core #(
   parameter int WIDTH = 4
) (
   output logic [WIDTH-1:0] s,
   output logic             carry,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic             en,
   input  logic             rst,
   input  logic             clk
);

   logic [WIDTH-1:0] sum_q   [WIDTH];
   logic [WIDTH-1:0] sum_d   [WIDTH];
   logic [WIDTH-1:0] a_q     [WIDTH];
   logic [WIDTH-1:0] a_d     [WIDTH];
   logic [WIDTH-1:0] b_q     [WIDTH];
   logic [WIDTH-1:0] b_d     [WIDTH];
   logic             carry_q [WIDTH];
   logic             carry_d [WIDTH];

   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   // Stage 0 reads the ports; its upper sum bits are zero so later stages can OR in their own bit.
   assign sum_d[0]   = WIDTH'(fa_sum(a[0], b[0], c));
   assign carry_d[0] = fa_carry(a[0], b[0], c);
   assign a_d[0]     = a;
   assign b_d[0]     = b;

   for (genvar k = 1; k < WIDTH; k++) begin : g_stage
      assign sum_d[k]   = sum_q[k-1]
                        | (WIDTH'(fa_sum(a_q[k-1][k], b_q[k-1][k], carry_q[k-1])) << k);
      assign carry_d[k] = fa_carry(a_q[k-1][k], b_q[k-1][k], carry_q[k-1]);
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q   <= '{default: '0};
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         carry_q <= '{default: 1'b0};
      end else if (en) begin
         sum_q   <= sum_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
      end
   end

   assign s     = sum_q[WIDTH-1];
   assign carry = carry_q[WIDTH-1];

endmodule

// File: tb/tb_fully_pipelined_adder_core.sv
// Bench for fully_pipelined_adder_core: a WIDTH=3 and a WIDTH=8 instance share clock, reset,
// enable and carry-in, and are checked every cycle against delay-line models of a+b+c.
module tb_fully_pipelined_adder_core;

   localparam int W3 = 3;
   localparam int W8 = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic          c   = 1'b0;
   logic [W3-1:0] a3  = '0;
   logic [W3-1:0] b3  = '0;
   logic [W8-1:0] a8  = '0;
   logic [W8-1:0] b8  = '0;
   logic [W3-1:0] s3;
   logic [W8-1:0] s8;
   logic          co3;
   logic          co8;

   int n_vec  = 0;
   int n_miss = 0;
   bit chk    = 1'b0;

   logic [W3:0] m3 [$];
   logic [W8:0] m8 [$];

   always #5 clk = ~clk;

   fully_pipelined_adder_core #(.WIDTH(W3)) dut3 (
      .s(s3), .carry(co3), .a(a3), .b(b3), .c(c), .en(en), .rst(rst), .clk(clk)
   );

   fully_pipelined_adder_core #(.WIDTH(W8)) dut8 (
      .s(s8), .carry(co8), .a(a8), .b(b8), .c(c), .en(en), .rst(rst), .clk(clk)
   );

   // Reference: each enabled edge records a+b+c; the output is the value recorded WIDTH edges ago.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m3.delete();
         m8.delete();
         for (int i = 0; i < W3; i++) m3.push_back('0);
         for (int i = 0; i < W8; i++) m8.push_back('0);
      end else if (en) begin
         m3.push_back((W3+1)'(a3) + (W3+1)'(b3) + (W3+1)'(c));
         m8.push_back((W8+1)'(a8) + (W8+1)'(b8) + (W8+1)'(c));
         void'(m3.pop_front());
         void'(m8.pop_front());
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         n_vec++;
         if ({co3, s3} !== m3[0]) begin
            n_miss++;
            $display("FAIL model_w3 t=%0t got %h expected %h", $time, {co3, s3}, m3[0]);
         end
         n_vec++;
         if ({co8, s8} !== m8[0]) begin
            n_miss++;
            $display("FAIL model_w8 t=%0t got %h expected %h", $time, {co8, s8}, m8[0]);
         end
      end
   end

   task automatic check_lit(input string name, input logic [W8:0] got, input logic [W8:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply3(input logic [W3-1:0] x, input logic [W3-1:0] y, input logic ci);
      a3 = x;
      b3 = y;
      c  = ci;
      a8 = W8'($urandom);
      b8 = W8'($urandom);
   endtask

   initial begin
      #2 rst = 1'b0;
      chk = 1'b1;
      repeat (3) step();
      check_lit("reset_w3", (W8+1)'({co3, s3}), '0);
      check_lit("reset_w8", {co8, s8}, '0);
      rst = 1'b1;
      repeat (3) step();
      check_lit("idle_after_reset_w3", (W8+1)'({co3, s3}), '0);
      check_lit("idle_after_reset_w8", {co8, s8}, '0);

      // Single operations, each observed WIDTH edges after being applied.
      en = 1'b1;
      apply3(3'd4, 3'd2, 1'b1);
      repeat (W3) step();
      check_lit("single_4_2_1", (W8+1)'({co3, s3}), 9'h007);
      apply3(3'd4, 3'd3, 1'b1);
      repeat (W3) step();
      check_lit("single_4_3_1", (W8+1)'({co3, s3}), 9'h008);
      apply3(3'd7, 3'd7, 1'b1);
      repeat (W3) step();
      check_lit("single_7_7_1", (W8+1)'({co3, s3}), 9'h00F);

      // Back-to-back operations.
      apply3(3'd4, 3'd2, 1'b1);
      step();
      apply3(3'd4, 3'd3, 1'b1);
      step();
      apply3(3'd7, 3'd7, 1'b1);
      step();
      check_lit("b2b_0", (W8+1)'({co3, s3}), 9'h007);
      apply3(3'd0, 3'd0, 1'b0);
      step();
      check_lit("b2b_1", (W8+1)'({co3, s3}), 9'h008);
      step();
      check_lit("b2b_2", (W8+1)'({co3, s3}), 9'h00F);

      // Stall with changing inputs.
      apply3(3'd7, 3'd7, 1'b1);
      step();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply3(W3'($urandom), W3'($urandom), 1'($urandom));
         step();
      end
      en = 1'b1;
      apply3(3'd0, 3'd0, 1'b0);
      repeat (2) step();
      check_lit("stall_7_7_1", (W8+1)'({co3, s3}), 9'h00F);

      // Reset while three operations are in flight.
      apply3(3'd4, 3'd2, 1'b1);
      step();
      apply3(3'd4, 3'd3, 1'b1);
      step();
      apply3(3'd7, 3'd7, 1'b1);
      step();
      #1 rst = 1'b0;
      #1;
      check_lit("midflight_rst_w3", (W8+1)'({co3, s3}), '0);
      check_lit("midflight_rst_w8", {co8, s8}, '0);
      #1 rst = 1'b1;
      a3 = '0; b3 = '0; a8 = '0; b8 = '0; c = 1'b0;
      for (int i = 0; i < W3; i++) begin
         step();
         check_lit("no_stale_w3", (W8+1)'({co3, s3}), '0);
      end

      // Random operands with random enable.
      for (int i = 0; i < 1000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         a3 = W3'($urandom);
         b3 = W3'($urandom);
         a8 = W8'($urandom);
         b8 = W8'($urandom);
         c  = 1'($urandom);
         step();
      end
      en = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; c = 1'b1; a3 = 3'd7; b3 = 3'd7;
      step();
      a8 = '0; b8 = '0; c = 1'b0; a3 = '0; b3 = '0;
      repeat (W8 - 1) step();
      check_lit("max_w8", {co8, s8}, 9'h1FF);
      repeat (2) step();
      @(negedge clk);
      #1 chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fully_pipelined_adder_core.md
# fully_pipelined_adder_core

WIDTH-bit adder with carry-in, pipelined at one bit per stage: stage k computes sum bit k and the carry into bit k+1. It accepts a new operand set every enabled clock and delivers each result a fixed WIDTH cycles later, with all sum bits aligned. It is a throughput-oriented arithmetic datapath element; it has no handshake beyond a global pipeline enable.

## Interface
Parameters:
- WIDTH, default 4, operand/sum width and pipeline depth (≥1).

Ports (in instantiation order s, carry, a, b, c, en, rst, clk):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; clears every pipeline register.
- s  output  WIDTH  registered sum (a+b+c) mod 2^WIDTH.
- carry  output  1  registered carry-out of bit WIDTH-1.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c  input  1  carry-in into bit 0.
- en  input  1  pipeline enable; 1 = advance all stages, 0 = hold all stages.

## Operation
- Stage k (k = 0..WIDTH-1) holds a register set:
  - sum bits 0..k, where bit k = a[k]^b[k]^cin_k;
  - carry register = majority(a[k], b[k], cin_k);
  - unprocessed operand bits a[WIDTH-1:k+1] and b[WIDTH-1:k+1].
- Stage 0 takes cin_0 = c and its operand bits directly from the a, b ports. Stage k>0 takes cin_k and the operand bits from stage k-1 registers.
- Output mapping:
  - s = stage WIDTH-1 sum register (all WIDTH bits).
  - carry = stage WIDTH-1 carry register.
  - No combinational path from inputs to outputs.
- Result: {carry, s} = a + b + c, i.e. a (WIDTH+1)-bit unsigned sum. No overflow condition exists.
- en=1: every stage loads from its predecessor; stage 0 loads from the ports.
- en=0: every register holds its value, the outputs are frozen, and port inputs are ignored.
- rst=0: all registers clear immediately regardless of clk or en, giving s=0 and carry=0. Operations in flight are discarded. After rst returns to 1, the outputs stay 0 until the first operand reaches the output.
- Each operand set is independent; the pipeline has no inter-operation state.

## Timing
- Latency: exactly WIDTH enabled rising edges. Operands sampled at enabled edge n appear on s/carry after enabled edge n+WIDTH-1.
  - Inputs applied mid-cycle before edge 1 are valid on the outputs after edge WIDTH, i.e. WIDTH clock periods later.
- Throughput: one operation per enabled cycle; back-to-back inputs produce back-to-back outputs in the same order.
- Stalls: cycles with en=0 add to latency one-for-one. Data is never lost or duplicated while stalled.
- Input changes while en=0 are not captured.
- Reset is asynchronous assertion. rst and en deassertion share the same setup requirement as data.
- Critical path per stage: one full-adder plus register.

## Test plan
- Reset: hold rst=0 with clk running and en=0 → s=0, carry=0. Deassert rst, keep en=0 for 3 cycles → outputs remain 0.
- Single ops, WIDTH=3, each checked WIDTH cycles after apply:
  - 4+2+1 → s=7, carry=0.
  - 4+3+1 → s=0, carry=1.
  - 7+7+1 → s=7, carry=1.
- Back-to-back, WIDTH=3, en=1: apply (4,2,1), (4,3,1), (7,7,1) on consecutive cycles → outputs 7/0, 0/1, 7/1 on consecutive cycles starting 3 cycles after the first apply.
- Stall: apply (7,7,1), drop en after 1 edge for 4 cycles while changing a, b, c, then raise en → result 7/1 appears after 2 more edges and is unaffected by the input changes.
- Reset mid-flight: WIDTH=3, issue 3 ops back-to-back, pulse rst=0 between clock edges → outputs 0 immediately; no stale results appear after release.
- Random: WIDTH=8, 1000 random (a, b, c) with random en → {carry, s} equals a+b+c in order, with latency WIDTH enabled edges.
